// File: rtl/bit_serial_adder_if.sv
// Operand/result bundle for bit_serial_adder: start/busy/done handshake plus operands and result.
// With BIT_SERIAL_ADDER_SUB_EN defined, a 'sub' request bit is carried alongside the operands.
interface bit_serial_adder_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef BIT_SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
`ifdef BIT_SERIAL_ADDER_SUB_EN
    output sub,
`endif
    input  busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
`ifdef BIT_SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    output busy, done, sum, cout
  );
endinterface

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: streams two WIDTH-bit operands LSB-first through one full adder and a carry flop.
// Optional subtract mode (b inverted, carry-in forced to 1) is enabled by BIT_SERIAL_ADDER_SUB_EN.
module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  bit_serial_adder_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             busy;
  logic             done;

  // One full-adder cell on the current LSBs.
  logic fa_s;
  logic fa_c;
  assign fa_s = a_sr[0] ^ b_sr[0] ^ carry;
  assign fa_c = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);

  // Operand B and carry-in as loaded on an accepted start.
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
`ifdef BIT_SERIAL_ADDER_SUB_EN
  assign b_load     = bus.sub ? ~bus.b : bus.b;
  assign carry_load = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_load     = bus.b;
  assign carry_load = bus.cin;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every variable written here gets a default first, so no latch can be inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = SHIFT;
      SHIFT:   if (count == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of the registered state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      carry  <= 1'b0;
      count  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_sr   <= bus.a;
            b_sr   <= b_load;
            carry  <= carry_load;
            count  <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
          end
        end
        SHIFT: begin
          carry <= fa_c;
          sum_q <= {fa_s, sum_q[WIDTH-1:1]};
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          // Saturate at the last step so the counter never wraps.
          if (count == LAST) begin
            cout_q <= fa_c;
          end else begin
            count <= count + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Directed self-checking bench for bit_serial_adder at WIDTH=4.
// Subtract-mode vectors run only when BIT_SERIAL_ADDER_SUB_EN is defined.
module tb_bit_serial_adder;

  localparam int W = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  bit_serial_adder_if #(.WIDTH(W)) bus ();

  bit_serial_adder #(.WIDTH(W)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Full operation: start pulse, WIDTH busy cycles, one done cycle, result held in IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input logic [W-1:0] exp_sum, input logic exp_cout);
    @(negedge clk);
    bus.a     = a;
    bus.b     = b;
    bus.cin   = ci;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int i = 0; i < W; i++) begin
      check({tag, " busy"}, 32'(bus.busy), 32'd1);
      check({tag, " done early"}, 32'(bus.done), 32'd0);
      @(negedge clk);
    end
    check({tag, " done"}, 32'(bus.done), 32'd1);
    check({tag, " busy at done"}, 32'(bus.busy), 32'd0);
    check({tag, " sum"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, " cout"}, 32'(bus.cout), 32'(exp_cout));
    @(negedge clk);
    check({tag, " done pulse width"}, 32'(bus.done), 32'd0);
    check({tag, " sum held"}, 32'(bus.sum), 32'(exp_sum));
    check({tag, " cout held"}, 32'(bus.cout), 32'(exp_cout));
  endtask

  initial begin
    int n;
    int d1;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.a     = '0;
    bus.b     = '0;
    bus.cin   = 1'b0;
`ifdef BIT_SERIAL_ADDER_SUB_EN
    bus.sub   = 1'b0;
`endif

    // 1: reset state, then 3+5
    repeat (2) @(negedge clk);
    check("reset busy", 32'(bus.busy), 32'd0);
    check("reset done", 32'(bus.done), 32'd0);
    check("reset sum", 32'(bus.sum), 32'd0);
    check("reset cout", 32'(bus.cout), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(bus.busy), 32'd0);
    run_op("3+5", 4'd3, 4'd5, 1'b0, 4'd8, 1'b0);

    // 2: carry-out boundaries
    run_op("15+1", 4'd15, 4'd1, 1'b0, 4'd0, 1'b1);
    run_op("15+15+1", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1);
    run_op("0+0+1", 4'd0, 4'd0, 1'b1, 4'd1, 1'b0);

    // 3: start during SHIFT is ignored and operand changes do not leak in
    @(negedge clk);
    bus.a = 4'd3; bus.b = 4'd5; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign shift1 busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    bus.a = 4'd1; bus.b = 4'd1; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("ign shift3 busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("ign shift4 busy", 32'(bus.busy), 32'd1);
    @(negedge clk);
    check("ign done", 32'(bus.done), 32'd1);
    check("ign sum", 32'(bus.sum), 32'd8);
    check("ign cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    check("ign back idle", 32'(bus.busy), 32'd0);
    check("ign no restart", 32'(bus.done), 32'd0);

    // 4: async reset in 3rd SHIFT cycle aborts the operation
    @(negedge clk);
    bus.a = 4'd15; bus.b = 4'd0; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort pre busy", 32'(bus.busy), 32'd1);
    check("abort partial sum", 32'(bus.sum), 32'd12);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(bus.busy), 32'd0);
    check("abort done", 32'(bus.done), 32'd0);
    check("abort sum", 32'(bus.sum), 32'd0);
    check("abort cout", 32'(bus.cout), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("abort no done", 32'(bus.done), 32'd0);
      check("abort stays idle", 32'(bus.busy), 32'd0);
      @(negedge clk);
    end
    run_op("7+2", 4'd7, 4'd2, 1'b0, 4'd9, 1'b0);

    // 5: start held high -> back-to-back ops every W+2 cycles
    @(negedge clk);
    bus.a = 4'd2; bus.b = 4'd2; bus.cin = 1'b0; bus.start = 1'b1;
    @(negedge clk);
    bus.a = 4'd6; bus.b = 4'd6;
    n = 0;
    while (!bus.done && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("b2b done1 seen", 32'(bus.done), 32'd1);
    check("b2b sum1", 32'(bus.sum), 32'd4);
    check("b2b cout1", 32'(bus.cout), 32'd0);
    d1 = n;
    @(negedge clk);
    n++;
    while (!bus.done && n < 40) begin
      @(negedge clk);
      n++;
    end
    bus.start = 1'b0;
    check("b2b done2 seen", 32'(bus.done), 32'd1);
    check("b2b period", 32'(n - d1), 32'(W + 2));
    check("b2b sum2", 32'(bus.sum), 32'd12);
    check("b2b cout2", 32'(bus.cout), 32'd0);
    @(negedge clk);
    check("b2b end idle", 32'(bus.busy), 32'd0);
    check("b2b end done", 32'(bus.done), 32'd0);

`ifdef BIT_SERIAL_ADDER_SUB_EN
    // 6: subtract mode; cin is ignored when sub=1
    bus.sub = 1'b1;
    run_op("5-3", 4'd5, 4'd3, 1'b0, 4'd2, 1'b1);
    run_op("3-5", 4'd3, 4'd5, 1'b1, 4'd14, 1'b0);
    bus.sub = 1'b0;
    run_op("sub0 3+5", 4'd3, 4'd5, 1'b0, 4'd8, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
